// File: rtl/locked_key_bank_pkg.sv
// Shared types and the gate evaluation helper for the locked key bank.
package locked_pkg;

  typedef enum logic [1:0] {
    GT_XOR  = 2'd0,
    GT_XNOR = 2'd1,
    GT_AND  = 2'd2,
    GT_OR   = 2'd3
  } gate_type_e;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    LOADING = 2'd1,
    FULL    = 2'd2,
    LOCKOUT = 2'd3
  } key_state_e;

  function automatic logic gate_eval(gate_type_e gt, logic d, logic k);
    logic q;
    case (gt)
      GT_XOR:  q = d ^ k;
      GT_XNOR: q = ~(d ^ k);
      GT_AND:  q = d & k;
      GT_OR:   q = d | k;
      default: q = d ^ k;
    endcase
    return q;
  endfunction

endpackage

// File: rtl/locked_key_bank_if.sv
// Key-load and datapath bus of the locked key bank.
interface locked_key_bank_if #(
  parameter int unsigned WIDTH = 8
);
  logic             key_sin;
  logic             key_shift;
  logic             key_commit;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             commit_ok;
  logic             commit_err;
  logic             key_loaded;
  logic             lockout;

  modport master (
    output key_sin, key_shift, key_commit, in_valid, in_data,
    input  out_valid, out_data, commit_ok, commit_err, key_loaded, lockout
  );

  modport slave (
    input  key_sin, key_shift, key_commit, in_valid, in_data,
    output out_valid, out_data, commit_ok, commit_err, key_loaded, lockout
  );
endinterface

// File: rtl/locked_key_bank_gate_cell.sv
// Single-bit combinational key gate with a fixed gate type.
module key_gate_cell
  import locked_pkg::*;
#(
  parameter gate_type_e GT = GT_XOR
) (
  input  logic i_d,
  input  logic i_k,
  output logic o_q_c
);
  assign o_q_c = gate_eval(GT, i_d, i_k);
endmodule

// File: rtl/locked_key_bank.sv
// Registered key-gate stage: serial shadow key load, guarded commit, attempt lockout.
module locked_key_bank
  import locked_pkg::*;
#(
  parameter int unsigned           WIDTH       = 8,
  parameter int unsigned           KEY_BITS    = 4,
  parameter logic [2*KEY_BITS-1:0] GATE_TYPES  = '0,
  parameter int unsigned           MAX_COMMITS = 3
) (
  input logic               clk,
  input logic               rst_n,
  locked_key_bank_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(KEY_BITS + 1);
  localparam int unsigned CMT_W = $clog2(MAX_COMMITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(KEY_BITS);
  localparam logic [CMT_W-1:0] CMT_MAX  = CMT_W'(MAX_COMMITS);

  key_state_e          r_state, w_state_nxt;
  logic [KEY_BITS-1:0] r_shadow, w_shadow_nxt;
  logic [KEY_BITS-1:0] r_active_key, w_active_nxt;
  logic [KEY_BITS-1:0] w_shifted;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [CMT_W-1:0]    r_commits, w_commits_nxt;
  logic                w_ok_nxt, w_err_nxt, w_loaded_nxt;

  logic                r_commit_ok, r_commit_err, r_key_loaded, r_lockout;
  logic                r_out_valid;
  logic [WIDTH-1:0]    r_out_data;
  logic [WIDTH-1:0]    w_gated;

  // First bit shifted in ends up in the MSB once the shadow is full.
  assign w_shifted = {r_shadow[KEY_BITS-2:0], bus.key_sin};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= EMPTY;
      r_shadow     <= '0;
      r_active_key <= '0;
      r_cnt        <= '0;
      r_commits    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_shadow     <= w_shadow_nxt;
      r_active_key <= w_active_nxt;
      r_cnt        <= w_cnt_nxt;
      r_commits    <= w_commits_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_shadow_nxt  = r_shadow;
    w_active_nxt  = r_active_key;
    w_cnt_nxt     = r_cnt;
    w_commits_nxt = r_commits;
    w_ok_nxt      = 1'b0;
    w_err_nxt     = 1'b0;
    w_loaded_nxt  = r_key_loaded;
    case (r_state)
      LOCKOUT: begin
        w_err_nxt = bus.key_commit;
      end
      FULL: begin
        if (bus.key_commit && !bus.key_shift) begin
          w_active_nxt  = r_shadow;
          w_cnt_nxt     = '0;
          w_commits_nxt = r_commits + CMT_W'(1);
          w_ok_nxt      = 1'b1;
          w_loaded_nxt  = 1'b1;
          w_state_nxt   = (w_commits_nxt == CMT_MAX) ? LOCKOUT : EMPTY;
        end else begin
          // Counter is saturated; extra shifts still move the shadow.
          w_err_nxt = bus.key_commit;
          if (bus.key_shift) w_shadow_nxt = w_shifted;
        end
      end
      default: begin
        w_err_nxt = bus.key_commit;
        if (bus.key_shift) begin
          w_shadow_nxt = w_shifted;
          w_cnt_nxt    = r_cnt + CNT_W'(1);
          w_state_nxt  = (w_cnt_nxt == CNT_FULL) ? FULL : LOADING;
        end
      end
    endcase
  end

  // Key gates on the low KEY_BITS bits, straight pass-through above.
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
    if (i < int'(KEY_BITS)) begin : g_gate
      key_gate_cell #(
        .GT(gate_type_e'(GATE_TYPES[2*i +: 2]))
      ) u_cell (
        .i_d   (bus.in_data[i]),
        .i_k   (r_active_key[i]),
        .o_q_c (w_gated[i])
      );
    end else begin : g_pass
      assign w_gated[i] = bus.in_data[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_commit_ok  <= 1'b0;
      r_commit_err <= 1'b0;
      r_key_loaded <= 1'b0;
      r_lockout    <= 1'b0;
    end else begin
      if (bus.in_valid) r_out_data <= w_gated;
      r_out_valid  <= bus.in_valid;
      r_commit_ok  <= w_ok_nxt;
      r_commit_err <= w_err_nxt;
      r_key_loaded <= w_loaded_nxt;
      r_lockout    <= (w_state_nxt == LOCKOUT);
    end
  end

  assign bus.out_data   = r_out_data;
  assign bus.out_valid  = r_out_valid;
  assign bus.commit_ok  = r_commit_ok;
  assign bus.commit_err = r_commit_err;
  assign bus.key_loaded = r_key_loaded;
  assign bus.lockout    = r_lockout;

endmodule
